// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the MIPS memory arbiter
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

endpackage

// File: rtl/mips_arb_prio.sv
// rtl/mips_arb_prio.sv - data-first priority select with fetch starvation counter
module mips_arb_prio
   import mips_mem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   input  logic grant,
   input  logic idle,
   output logic winner
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

   logic [3:0] starve_cnt;

   // Fetch wins a tie only once it has lost MAX_WAIT grants in a row.
   always_comb begin
      winner = OWN_I;
      if (d_req && !(i_req && starve_cnt == MAX_CNT))
         winner = OWN_D;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (idle && !i_req) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (winner == OWN_I)
            starve_cnt <= '0;
         else if (starve_cnt != MAX_CNT)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port memory arbiter for MIPS IF/MEM stages
// Optional statistics counters enabled by MIPS_MEM_ARB_STATS_EN.
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_WAIT = 4,
   parameter int STAT_W   = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_rdy,
   input  logic [DW-1:0] mem_rdata
`ifdef MIPS_MEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_i_grants,
   output logic [STAT_W-1:0] stat_d_grants,
   output logic [STAT_W-1:0] stat_stall_cycles
`endif
);

   state_t state;
   logic   owner;
   logic   grant;
   logic   idle;
   logic   winner;

   always_comb begin
      idle  = (state == IDLE);
      grant = idle && (i_req || d_req);
   end

   mips_arb_prio #(
      .MAX_WAIT(MAX_WAIT)
   ) u_prio (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (i_req),
      .d_req (d_req),
      .grant (grant),
      .idle  (idle),
      .winner(winner)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_I;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         i_ack  <= 1'b0;
         d_ack  <= 1'b0;
         mem_en <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner  <= winner;
                  mem_en <= 1'b1;
                  state  <= WAIT;
                  if (winner == OWN_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= i_addr;
                  end
               end
            end
            WAIT: begin
               // Command fields stay put until memory completes.
               if (mem_rdy) begin
                  state <= RESP;
                  if (owner == OWN_D) begin
                     d_rdata <= mem_rdata;
                     d_ack   <= 1'b1;
                  end else begin
                     i_rdata <= mem_rdata;
                     i_ack   <= 1'b1;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MIPS_MEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_i_grants     <= '0;
         stat_d_grants     <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (grant && winner == OWN_I)
            stat_i_grants <= stat_i_grants + 1'b1;
         if (grant && winner == OWN_D)
            stat_d_grants <= stat_d_grants + 1'b1;
         if (i_req && !i_ack)
            stat_stall_cycles <= stat_stall_cycles + 1'b1;
      end
   end
`endif

endmodule
